// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on stall/flush,
// freeze on hold, and a saturating count of load-use bubbles.
module idex_stage_reg #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic [1:0]       id_wb_i,
  input  logic [1:0]       id_m_i,
  input  logic [3:0]       id_ex_i,
  input  logic [31:0]      id_rs_data_i,
  input  logic [31:0]      id_rt_data_i,
  input  logic [31:0]      id_imm_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic [4:0]       id_rd_i,
  output logic [1:0]       idex_wb_o,
  output logic [1:0]       idex_m_o,
  output logic [3:0]       idex_ex_o,
  output logic [31:0]      idex_rs_data_o,
  output logic [31:0]      idex_rt_data_o,
  output logic [31:0]      idex_imm_o,
  output logic [4:0]       idex_rs_o,
  output logic [4:0]       idex_rt_o,
  output logic [4:0]       idex_rd_o,
  output logic             idex_valid_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [1:0]       wb_q, wb_d;
  logic [1:0]       m_q, m_d;
  logic [3:0]       ex_q, ex_d;
  logic [31:0]      rs_data_q, rs_data_d;
  logic [31:0]      rt_data_q, rt_data_d;
  logic [31:0]      imm_q, imm_d;
  logic [4:0]       rs_q, rs_d;
  logic [4:0]       rt_q, rt_d;
  logic [4:0]       rd_q, rd_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  // A load in EX whose destination (rt) feeds a source of the instruction in ID.
  assign stall = valid_q & m_q[1] & (rt_q != 5'd0) &
                 ((rt_q == id_rs_i) | (rt_q == id_rt_i));

  always_comb begin
    wb_d      = wb_q;
    m_d       = m_q;
    ex_d      = ex_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    if (!hold_i) begin
      if (flush_i || stall) begin
        wb_d      = '0;
        m_d       = '0;
        ex_d      = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        imm_d     = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        valid_d   = 1'b0;
      end else begin
        wb_d      = id_wb_i;
        m_d       = id_m_i;
        ex_d      = id_ex_i;
        rs_data_d = id_rs_data_i;
        rt_data_d = id_rt_data_i;
        imm_d     = id_imm_i;
        rs_d      = id_rs_i;
        rt_d      = id_rt_i;
        rd_d      = id_rd_i;
        valid_d   = 1'b1;
      end
      // Only load-use bubbles count; a coincident flush takes the credit.
      if (stall && !flush_i && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wb_q      <= '0;
      m_q       <= '0;
      ex_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wb_q      <= wb_d;
      m_q       <= m_d;
      ex_q      <= ex_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign idex_wb_o      = wb_q;
  assign idex_m_o       = m_q;
  assign idex_ex_o      = ex_q;
  assign idex_rs_data_o = rs_data_q;
  assign idex_rt_data_o = rt_data_q;
  assign idex_imm_o     = imm_q;
  assign idex_rs_o      = rs_q;
  assign idex_rt_o      = rt_q;
  assign idex_rd_o      = rd_q;
  assign idex_valid_o   = valid_q;
  assign stall_o        = stall;
  assign bubble_cnt_o   = cnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: directed vector table, saturation sequence and random traffic,
// all checked against a behavioural model of the EX-stage slot.
module tb_idex_stage_reg;

  localparam int unsigned TbCntW = 2;
  localparam int          CntMax = (1 << TbCntW) - 1;

  logic              clk_i = 1'b0;
  logic              rst_i, hold_i, flush_i;
  logic [1:0]        id_wb_i, id_m_i;
  logic [3:0]        id_ex_i;
  logic [31:0]       id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]        id_rs_i, id_rt_i, id_rd_i;
  logic [1:0]        idex_wb_o, idex_m_o;
  logic [3:0]        idex_ex_o;
  logic [31:0]       idex_rs_data_o, idex_rt_data_o, idex_imm_o;
  logic [4:0]        idex_rs_o, idex_rt_o, idex_rd_o;
  logic              idex_valid_o, stall_o;
  logic [TbCntW-1:0] bubble_cnt_o;

  idex_stage_reg #(.CNT_W(TbCntW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .hold_i         (hold_i),
    .flush_i        (flush_i),
    .id_wb_i        (id_wb_i),
    .id_m_i         (id_m_i),
    .id_ex_i        (id_ex_i),
    .id_rs_data_i   (id_rs_data_i),
    .id_rt_data_i   (id_rt_data_i),
    .id_imm_i       (id_imm_i),
    .id_rs_i        (id_rs_i),
    .id_rt_i        (id_rt_i),
    .id_rd_i        (id_rd_i),
    .idex_wb_o      (idex_wb_o),
    .idex_m_o       (idex_m_o),
    .idex_ex_o      (idex_ex_o),
    .idex_rs_data_o (idex_rs_data_o),
    .idex_rt_data_o (idex_rt_data_o),
    .idex_imm_o     (idex_imm_o),
    .idex_rs_o      (idex_rs_o),
    .idex_rt_o      (idex_rt_o),
    .idex_rd_o      (idex_rd_o),
    .idex_valid_o   (idex_valid_o),
    .stall_o        (stall_o),
    .bubble_cnt_o   (bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst, hold, flush;
    logic [1:0]  wb, m;
    logic [3:0]  ex;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic        chk_stall, e_stall, e_valid;
    logic [1:0]  e_cnt;
    logic [4:0]  e_rt;
  } vec_t;

  // Model: the instruction occupying EX (a bubble is an all-zero slot) plus a bubble tally.
  typedef struct {
    logic        valid;
    logic [1:0]  wb, m;
    logic [3:0]  ex;
    logic [31:0] rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
  } slot_t;

  slot_t mdl;
  int    mdl_bubbles;
  bit    mdl_known;
  int    checks, passes;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rst, hold, flush, input logic [1:0] wb, m,
                              input logic [3:0] ex, input logic [4:0] rs, rt, rd,
                              input logic [31:0] rsd, input logic cs, es, ev,
                              input logic [1:0] ec, input logic [4:0] ert);
    vec_t v;
    v.rst = rst; v.hold = hold; v.flush = flush;
    v.wb = wb; v.m = m; v.ex = ex; v.rs = rs; v.rt = rt; v.rd = rd;
    v.rsd = rsd; v.rtd = ~rsd; v.imm = rsd + 32'd1;
    v.chk_stall = cs; v.e_stall = es; v.e_valid = ev; v.e_cnt = ec; v.e_rt = ert;
    return v;
  endfunction

  function automatic logic model_hazard(input vec_t v);
    // A load's result is not ready for the very next instruction that reads it.
    bit is_load = mdl.valid && mdl.m[1];
    return is_load && (mdl.rt != 0) && (mdl.rt == v.rs || mdl.rt == v.rt);
  endfunction

  function automatic logic [127:0] dut_out();
    return {idex_wb_o, idex_m_o, idex_ex_o, idex_rs_data_o, idex_rt_data_o, idex_imm_o,
            idex_rs_o, idex_rt_o, idex_rd_o, idex_valid_o, bubble_cnt_o};
  endfunction

  function automatic logic [127:0] mdl_out();
    logic [TbCntW-1:0] c = TbCntW'(mdl_bubbles);
    return {mdl.wb, mdl.m, mdl.ex, mdl.rsd, mdl.rtd, mdl.imm,
            mdl.rs, mdl.rt, mdl.rd, mdl.valid, c};
  endfunction

  task automatic step(input vec_t v);
    logic hz;
    rst_i = v.rst; hold_i = v.hold; flush_i = v.flush;
    id_wb_i = v.wb; id_m_i = v.m; id_ex_i = v.ex;
    id_rs_data_i = v.rsd; id_rt_data_i = v.rtd; id_imm_i = v.imm;
    id_rs_i = v.rs; id_rt_i = v.rt; id_rd_i = v.rd;
    #1;
    hz = model_hazard(v);
    if (mdl_known) chk("stall_model", 128'(stall_o), 128'(hz));
    @(posedge clk_i);
    if (!v.rst) begin
      mdl = '{default: '0};
      mdl_bubbles = 0;
      mdl_known = 1'b1;
    end else if (!v.hold) begin
      if (v.flush || hz) begin
        mdl = '{default: '0};
        if (!v.flush && mdl_bubbles < CntMax) mdl_bubbles++;
      end else begin
        mdl = '{valid: 1'b1, wb: v.wb, m: v.m, ex: v.ex, rsd: v.rsd, rtd: v.rtd,
                imm: v.imm, rs: v.rs, rt: v.rt, rd: v.rd};
      end
    end
    #1;
    if (mdl_known) chk("outputs_model", dut_out(), mdl_out());
  endtask

  vec_t tbl[14];
  vec_t v;

  initial begin
    checks = 0; passes = 0; mdl_known = 1'b0; mdl_bubbles = 0;
    mdl = '{default: '0};
    //             rst h f  wb     m      ex       rs rt rd rsd            cs es ev ec rt
    tbl[0]  = mk(0, 0, 0, 2'b11, 2'b10, 4'hF,    4, 4, 7, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 2'b11, 2'b10, 4'hF,    4, 4, 7, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 2'b10, 2'b00, 4'b1001, 3, 4, 5, 32'h1234,      1, 0, 1, 0, 4);
    tbl[3]  = mk(1, 0, 0, 2'b11, 2'b10, 4'b1010, 2, 4, 0, 32'h100,       1, 0, 1, 0, 4);
    tbl[4]  = mk(1, 0, 0, 2'b10, 2'b00, 4'b0011, 4, 6, 7, 32'h55,        1, 1, 0, 1, 0);
    tbl[5]  = mk(1, 0, 0, 2'b10, 2'b00, 4'b0011, 4, 6, 7, 32'h55,        1, 0, 1, 1, 6);
    tbl[6]  = mk(1, 0, 0, 2'b11, 2'b10, 4'b1010, 1, 0, 0, 32'h66,        1, 0, 1, 1, 0);
    tbl[7]  = mk(1, 0, 0, 2'b11, 2'b10, 4'b1010, 0, 9, 0, 32'h77,        1, 0, 1, 1, 9);
    tbl[8]  = mk(1, 1, 1, 2'b10, 2'b00, 4'b0011, 9, 2, 3, 32'h88,        1, 1, 1, 1, 9);
    tbl[9]  = mk(1, 1, 1, 2'b10, 2'b00, 4'b0011, 9, 2, 3, 32'h88,        1, 1, 1, 1, 9);
    tbl[10] = mk(1, 0, 1, 2'b10, 2'b00, 4'b0011, 9, 2, 3, 32'h88,        1, 1, 0, 1, 0);
    tbl[11] = mk(1, 0, 0, 2'b11, 2'b10, 4'b1010, 1, 5, 0, 32'hAA,        1, 0, 1, 1, 5);
    tbl[12] = mk(0, 0, 0, 2'b10, 2'b00, 4'b0011, 5, 2, 3, 32'hBB,        1, 1, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 2'b10, 2'b00, 4'b0011, 5, 3, 3, 32'hCC,        1, 0, 1, 0, 3);

    for (int i = 0; i < 14; i++) begin
      rst_i = tbl[i].rst; hold_i = tbl[i].hold; flush_i = tbl[i].flush;
      id_rs_i = tbl[i].rs; id_rt_i = tbl[i].rt;
      #1;
      if (tbl[i].chk_stall) chk($sformatf("tbl%0d_stall", i), 128'(stall_o),
                                128'(tbl[i].e_stall));
      step(tbl[i]);
      chk($sformatf("tbl%0d_valid", i), 128'(idex_valid_o), 128'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_cnt", i), 128'(bubble_cnt_o), 128'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_rt", i), 128'(idex_rt_o), 128'(tbl[i].e_rt));
    end

    // Saturation: five load-use stalls from a fresh reset, counter must stick at 3.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      logic [4:0] r = 5'(k + 10);
      step(mk(1, 0, 0, 2'b11, 2'b10, 4'b1010, 1, r, 0, 32'h1000 + k, 0, 0, 0, 0, 0));
      step(mk(1, 0, 0, 2'b10, 2'b00, 4'b0011, 2, r, 8, 32'h2000 + k, 0, 0, 0, 0, 0));
      chk($sformatf("sat%0d_cnt", k), 128'(bubble_cnt_o), 128'((k > 3) ? 3 : k));
      chk($sformatf("sat%0d_bubble", k), 128'(idex_valid_o), 128'(0));
      step(mk(1, 0, 0, 2'b10, 2'b00, 4'b0011, 2, r, 8, 32'h2000 + k, 0, 0, 0, 0, 0));
      chk($sformatf("sat%0d_dep_rt", k), 128'(idex_rt_o), 128'(r));
    end

    // Random traffic with small register numbers so hazards are frequent.
    for (int n = 0; n < 400; n++) begin
      v.rst   = ($urandom_range(0, 31) != 0);
      v.hold  = ($urandom_range(0, 7) == 0);
      v.flush = ($urandom_range(0, 7) == 0);
      v.wb    = 2'($urandom); v.m = 2'($urandom); v.ex = 4'($urandom);
      v.rsd   = $urandom; v.rtd = $urandom; v.imm = $urandom;
      v.rs    = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
      v.rd    = 5'($urandom);
      v.chk_stall = 0; v.e_stall = 0; v.e_valid = 0; v.e_cnt = 0; v.e_rt = 0;
      step(v);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
